fifo_write_arbiter: RTL and testbench



---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_write_arbiter_rr_pick.sv | 33 +++
 rtl/fifo_write_arbiter.sv | 136 +++++++++++++
 tb/tb_fifo_write_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write-side arbitration logic.
package fifo_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_BURST
  } arb_state_t;

  // Per-requester transfer counters are 16 bits wide and saturate.
  localparam int STATS_CNT_WIDTH = 16;

  // Width of a counter or index able to hold 0..n-1, never less than 1 bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin selector: the winner is the first request found
// searching upward from the slot after last_grant, wrapping around.
module rr_pick
  import fifo_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = cnt_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     winner,
  output logic             any_req
);

  int  idx;
  logic found;

  // Scan all N slots once, starting just after the previous owner.
  always_comb begin
    winner  = '0;
    found   = 1'b0;
    idx     = 0;
    any_req = |req;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_grant) + k) % N;
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing the FIFO write port among NUM_REQ
// requesters. Writes are gated by the registered write_full flag.
// Optional per-requester word counters: define FIFO_WRITE_ARB_STATS_EN.
module fifo_write_arbiter
  import fifo_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          write_clock,
  input  logic                          write_reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          write_full,
  output logic                          write_enable,
  output logic [DATA_WIDTH-1:0]         write_data,
  output logic [NUM_REQ-1:0]            arb_grant,
  output logic                          arb_busy
`ifdef FIFO_WRITE_ARB_STATS_EN
  ,output logic [NUM_REQ*STATS_CNT_WIDTH-1:0] arb_word_count
`endif
);

  localparam int IDX_W = cnt_width(NUM_REQ);
  localparam int CNT_W = cnt_width(MAX_BURST);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

  arb_state_t         state, state_next;
  logic [NUM_REQ-1:0] grant_next;
  logic [IDX_W-1:0]   last_grant, last_next;
  logic [CNT_W-1:0]   burst_cnt, cnt_next;
  logic [NUM_REQ-1:0] pick_onehot;
  logic               any_req;
  logic [IDX_W-1:0]   pick_idx;

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req        (req_valid),
    .last_grant (last_grant),
    .winner     (pick_onehot),
    .any_req    (any_req)
  );

  // Turn the one-hot winner into an index for last_grant.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_onehot[i]) pick_idx = IDX_W'(i);
    end
  end

  // Handshake outputs: only the owner may be ready, and never while full or in reset.
  always_comb begin
    req_ready    = '0;
    write_enable = 1'b0;
    write_data   = req_data[int'(last_grant)*DATA_WIDTH +: DATA_WIDTH];
    arb_busy     = (state == ARB_BURST);
    if (state == ARB_BURST && !write_reset) begin
      req_ready[last_grant] = ~write_full;
      write_enable          = req_valid[last_grant] & ~write_full;
    end
  end

  // Next state: arbitrate in IDLE; in BURST end on the last word or on release.
  always_comb begin
    state_next = state;
    grant_next = arb_grant;
    last_next  = last_grant;
    cnt_next   = burst_cnt;
    case (state)
      ARB_IDLE: begin
        if (any_req) begin
          state_next = ARB_BURST;
          grant_next = pick_onehot;
          last_next  = pick_idx;
          cnt_next   = '0;
        end
      end
      ARB_BURST: begin
        if (write_enable) begin
          if (burst_cnt == BURST_LAST) begin
            state_next = ARB_IDLE;
            grant_next = '0;
            cnt_next   = '0;
          end else begin
            cnt_next = burst_cnt + CNT_W'(1);
          end
        end else if (!write_full && !req_valid[last_grant]) begin
          state_next = ARB_IDLE;
          grant_next = '0;
        end
      end
      default: begin
        state_next = ARB_IDLE;
        grant_next = '0;
      end
    endcase
  end

  // State register; reset makes requester 0 the first winner.
  always_ff @(posedge write_clock) begin
    if (write_reset) begin
      state      <= ARB_IDLE;
      arb_grant  <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
      burst_cnt  <= '0;
    end else begin
      state      <= state_next;
      arb_grant  <= grant_next;
      last_grant <= last_next;
      burst_cnt  <= cnt_next;
    end
  end

`ifdef FIFO_WRITE_ARB_STATS_EN
  // Saturating per-requester word counters.
  always_ff @(posedge write_clock) begin
    if (write_reset) begin
      arb_word_count <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (write_enable && int'(last_grant) == i &&
            arb_word_count[i*STATS_CNT_WIDTH +: STATS_CNT_WIDTH] != {STATS_CNT_WIDTH{1'b1}}) begin
          arb_word_count[i*STATS_CNT_WIDTH +: STATS_CNT_WIDTH] <=
            arb_word_count[i*STATS_CNT_WIDTH +: STATS_CNT_WIDTH] + STATS_CNT_WIDTH'(1);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Testbench for fifo_write_arbiter: directed requester traffic against a
// bench-side FIFO occupancy model and an arbitration reference model.
module tb_fifo_write_arbiter;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int MB    = 4;
  localparam int DEPTH = 16;

  logic            write_clock = 1'b0;
  logic            write_reset;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            write_full;
  logic            write_enable;
  logic [DW-1:0]   write_data;
  logic [N-1:0]    arb_grant;
  logic            arb_busy;
`ifdef FIFO_WRITE_ARB_STATS_EN
  logic [N*16-1:0] arb_word_count;
`endif

  fifo_write_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .write_clock  (write_clock),
    .write_reset  (write_reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .write_full   (write_full),
    .write_enable (write_enable),
    .write_data   (write_data),
    .arb_grant    (arb_grant),
    .arb_busy     (arb_busy)
`ifdef FIFO_WRITE_ARB_STATS_EN
    ,.arb_word_count (arb_word_count)
`endif
  );

  always #5 write_clock = ~write_clock;

  int remaining [N];
  int seq       [N];
  int writes    [N];
  int fifo_count;
  bit auto_read;
  int read_pulses;
  logic [N-1:0] xfer_obs;
  logic         we_obs;

  int m_owner;
  int m_last;
  int m_words;

  int total_checks  = 0;
  int passed_checks = 0;
  int grant_log [$];
  logic [N-1:0] prev_grant;
  bit checking = 1'b0;

  task automatic check(input string name, input int actual, input int expected);
    total_checks++;
    if (actual == expected) passed_checks++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
  endtask

  function automatic logic [DW-1:0] word_of(input int i, input int s);
    return DW'(i * 64 + (s % 64));
  endfunction

  task automatic applyStimulus();
    for (int i = 0; i < N; i++) begin
      req_valid[i]         = (remaining[i] > 0);
      req_data[i*DW +: DW] = word_of(i, seq[i]);
    end
  endtask

  // Reference arbitration: round robin from the slot after the last owner,
  // a burst ends after MB words or when the owner drops valid while not full.
  task automatic model_step();
    bit found;
    int c;
    if (write_reset) begin
      m_owner = -1;
      m_last  = N - 1;
      m_words = 0;
    end else if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (!found && req_valid[c]) begin
          found   = 1'b1;
          m_owner = c;
          m_last  = c;
          m_words = 0;
        end
      end
    end else if (!write_full) begin
      if (req_valid[m_owner]) begin
        m_words++;
        if (m_words == MB) m_owner = -1;
      end else begin
        m_owner = -1;
      end
    end
  endtask

  // Environment: advance model, FIFO occupancy and requesters on each edge.
  initial begin
    bit rd;
    forever begin
      @(posedge write_clock);
      model_step();
      rd = (auto_read || read_pulses > 0) && fifo_count > 0;
      if (rd && !auto_read) read_pulses--;
      fifo_count = fifo_count + int'(we_obs) - int'(rd);
      for (int i = 0; i < N; i++) begin
        if (xfer_obs[i]) begin
          remaining[i]--;
          seq[i]++;
          writes[i]++;
        end
      end
      #1;
      write_full = (fifo_count >= DEPTH);
      applyStimulus();
    end
  end

  // Compare DUT outputs with the model every cycle, away from the clock edge.
  initial begin
    logic [N-1:0] exp_grant, exp_ready;
    bit exp_we;
    forever begin
      @(negedge write_clock);
      if (checking) begin
        exp_grant = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        exp_ready = (m_owner >= 0 && !write_reset && !write_full) ? (N'(1) << m_owner) : '0;
        exp_we    = (m_owner >= 0) && !write_reset && !write_full && req_valid[m_owner];
        check("arb_grant", int'(arb_grant), int'(exp_grant));
        check("arb_busy", int'(arb_busy), int'(m_owner >= 0));
        check("req_ready", int'(req_ready), int'(exp_ready));
        check("write_enable", int'(write_enable), int'(exp_we));
        if (exp_we) check("write_data", int'(write_data), int'(word_of(m_owner, seq[m_owner])));
        if (write_enable) check("room_on_write", int'(fifo_count < DEPTH), 1);
        if (arb_grant != prev_grant && arb_grant != '0) begin
          for (int i = 0; i < N; i++) if (arb_grant[i]) grant_log.push_back(i);
        end
        prev_grant = arb_grant;
      end
      we_obs   = write_enable;
      xfer_obs = req_ready & req_valid;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge write_clock);
    #2;
  endtask

  task automatic clear_env();
    for (int i = 0; i < N; i++) begin
      remaining[i] = 0;
      writes[i]    = 0;
    end
    grant_log.delete();
    applyStimulus();
  endtask

  task automatic do_reset();
    clear_env();
    write_reset = 1'b1;
    cycles(1);
    write_reset = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      done = !arb_busy;
      for (int i = 0; i < N; i++) if (remaining[i] > 0) done = 1'b0;
      if (!done) cycles(1);
    end
    check(name, int'(done), 1);
    cycles(1);
  endtask

  task automatic checkOutput(input string name, input int got[$], input int exp[$]);
    check({name, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s_%0d", name, i), got[i], exp[i]);
  endtask

  initial begin
    int wr_budget;
    for (int i = 0; i < N; i++) seq[i] = 0;
    fifo_count  = 0;
    auto_read   = 1'b1;
    read_pulses = 0;
    write_full  = 1'b0;
    write_reset = 1'b1;
    we_obs      = 1'b0;
    xfer_obs    = '0;
    prev_grant  = '0;
    m_owner = -1; m_last = N - 1; m_words = 0;
    clear_env();
    cycles(1);
    checking    = 1'b1;
    write_reset = 1'b0;

    @(negedge write_clock);
    check("reset_grant", int'(arb_grant), 0);
    check("reset_busy", int'(arb_busy), 0);
    check("reset_ready", int'(req_ready), 0);
    check("reset_we", int'(write_enable), 0);
    cycles(1);

    // Round robin with everyone streaming: two full rotations of 4-word bursts.
    $display("[TB] round robin");
    clear_env();
    for (int i = 0; i < N; i++) remaining[i] = 8;
    applyStimulus();
    wait_drain("rr_drain", 200);
    checkOutput("rr_order", grant_log, '{0, 1, 2, 3, 0, 1, 2, 3});
    for (int i = 0; i < N; i++) check($sformatf("rr_writes_%0d", i), writes[i], 8);

    // Early release by requester 1 hands over to requester 2.
    $display("[TB] early release");
    do_reset();
    remaining[1] = 2;
    remaining[2] = 3;
    applyStimulus();
    wait_drain("rel_drain", 100);
    checkOutput("rel_order", grant_log, '{1, 2});
    check("rel_writes_1", writes[1], 2);
    check("rel_writes_2", writes[2], 3);

    // Full stall: no reads, exactly DEPTH words go in, then single reads let one more through each.
    $display("[TB] full stall");
    do_reset();
    auto_read  = 1'b0;
    fifo_count = 0;
    remaining[0] = 20;
    applyStimulus();
    cycles(40);
    check("full_writes_16", writes[0], 16);
    check("full_count", fifo_count, DEPTH);
    @(negedge write_clock);
    check("full_ready0", int'(req_ready[0]), 0);
    check("full_we", int'(write_enable), 0);
    cycles(1);
    read_pulses = 1;
    cycles(6);
    check("full_writes_17", writes[0], 17);
    read_pulses = 1;
    cycles(6);
    check("full_writes_18", writes[0], 18);
    auto_read = 1'b1;
    wait_drain("full_drain", 100);
    check("full_writes_20", writes[0], 20);

    // Wrap: after requester 3 owns the port, requester 0 beats requester 3.
    $display("[TB] wrap priority");
    do_reset();
    remaining[3] = 1;
    applyStimulus();
    wait_drain("wrap_drain1", 50);
    remaining[0] = 1;
    remaining[3] = 1;
    applyStimulus();
    wait_drain("wrap_drain2", 50);
    checkOutput("wrap_order", grant_log, '{3, 0, 3});

    // Reset in the middle of a burst from requester 2.
    $display("[TB] reset mid-burst");
    do_reset();
    remaining[2] = 10;
    applyStimulus();
    wr_budget = 0;
    while (writes[2] < 2 && wr_budget < 50) begin
      cycles(1);
      wr_budget++;
    end
    check("mid_two_words", writes[2], 2);
    remaining[2] = 0;
    remaining[0] = 1;
    applyStimulus();
    write_reset = 1'b1;
    cycles(1);
    write_reset = 1'b0;
    @(negedge write_clock);
    check("mid_grant", int'(arb_grant), 0);
    check("mid_ready", int'(req_ready), 0);
    check("mid_we", int'(write_enable), 0);
    cycles(1);
    wait_drain("mid_drain", 50);
    checkOutput("mid_order", grant_log, '{2, 0});
    check("mid_writes_0", writes[0], 1);

`ifdef FIFO_WRITE_ARB_STATS_EN
    // Word counters: twenty words from requester 1 only.
    $display("[TB] stats");
    do_reset();
    check("stats_clear", int'(arb_word_count[16 +: 16]), 0);
    remaining[1] = 20;
    applyStimulus();
    wait_drain("stats_drain", 100);
    for (int i = 0; i < N; i++)
      check($sformatf("stats_cnt_%0d", i), int'(arb_word_count[i*16 +: 16]), (i == 1) ? 20 : 0);
`endif

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
